// File: rtl/sparc_control_unit_pkg.sv
// Shared definitions for the SPARC control unit: state encodings, ALU
// opcodes, datapath mux-select values and the instruction decode helper.
package sparc_control_unit_pkg;

  // Loads and stores share one address-generation state (S_LDSTA). Both
  // compute rs1 + (rs2 | simm13) into MAR, so one state covers them and all
  // sixteen states fit the 4-bit State bus. op3[2] picks the data phase.
  typedef enum logic [3:0] {
    S_RESET = 4'd0,
    S_INIT  = 4'd1,
    S_F0    = 4'd2,
    S_F1    = 4'd3,
    S_DEC   = 4'd4,
    S_ALU   = 4'd5,
    S_SETHI = 4'd6,
    S_LDSTA = 4'd7,
    S_LDM   = 4'd8,
    S_LDW   = 4'd9,
    S_STD   = 4'd10,
    S_STM   = 4'd11,
    S_BR    = 4'd12,
    S_CALL  = 4'd13,
    S_PCU   = 4'd14,
    S_ERROR = 4'd15
  } state_t;

  localparam logic [5:0] OP_ADD    = 6'b000000;
  localparam logic [5:0] OP_PASS_A = 6'b111110;
  localparam logic [5:0] OP_PASS_B = 6'b111111;

  localparam logic [1:0] MB_RF    = 2'b00;
  localparam logic [1:0] MB_IMM   = 2'b01;
  localparam logic [1:0] MB_MUXC  = 2'b10;
  localparam logic [1:0] MB_MDR   = 2'b11;
  localparam logic [1:0] MP_ZERO  = 2'b00;
  localparam logic [1:0] MP_NPC   = 2'b11;
  localparam logic [1:0] MNP_NPC4 = 2'b11;
  localparam logic [1:0] MNP_DISP = 2'b10;
  localparam logic [1:0] MSC_RD   = 2'b00;
  localparam logic [1:0] MSC_R15  = 2'b01;

  localparam logic [1:0] TYPE_WORD = 2'b10;

  // State reached from S_DEC. S_PCU doubles as the "unsupported" target:
  // the instruction is skipped and Illegal is flagged by the caller.
  // For format-2 (op=00) op2 is IR[24:22], i.e. op3[5:3].
  function automatic state_t decode_target(input logic [1:0] op,
                                           input logic [5:0] op3);
    state_t nxt;
    nxt = S_PCU;
    case (op)
      2'b10: if (op3[5:4] == 2'b00) nxt = S_ALU;
      2'b11: if (op3 == 6'b000000 || op3 == 6'b000100) nxt = S_LDSTA;
      2'b00: begin
        if (op3[5:3] == 3'b100)      nxt = S_SETHI;
        else if (op3[5:3] == 3'b010) nxt = S_BR;
      end
      default: nxt = S_CALL;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sparc_control_unit_if.sv
// Control-unit <-> datapath bundle.
//   master: the control unit (consumes IR/MOC/BCOND/TCOND, drives strobes)
//   slave : the datapath/memory side
interface sparc_control_unit_if;
  logic [31:0] IR;
  logic        MOC;
  logic        BCOND;
  logic        TCOND;

  logic        IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr;
  logic        RF_Load_Enable, FR_Ld;
  logic        MOV, RW;
  logic [1:0]  Type;
  logic [1:0]  MA, MB, MNP, MP, MSc;
  logic        MC, MM, MSa, MOP;
  logic [5:0]  OpXX;
  logic        Err, Illegal;
  logic [3:0]  State;

  modport master (
    input  IR, MOC, BCOND, TCOND,
    output IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr,
           RF_Load_Enable, FR_Ld, MOV, RW, Type,
           MA, MB, MNP, MP, MSc, MC, MM, MSa, MOP, OpXX,
           Err, Illegal, State
  );

  modport slave (
    output IR, MOC, BCOND, TCOND,
    input  IR_Ld, MAR_Ld, MDR_Ld, PC_Ld, NPC_Ld, nPC_Clr,
           RF_Load_Enable, FR_Ld, MOV, RW, Type,
           MA, MB, MNP, MP, MSc, MC, MM, MSa, MOP, OpXX,
           Err, Illegal, State
  );
endinterface

// File: rtl/sparc_mem_wait.sv
// MOC handshake watchdog shared by the three memory-wait states.
//   Clk     : clock, rising edge
//   Clr     : synchronous active-high reset
//   in_wait : the sequencer is in a memory-wait state
//   moc     : memory operation complete
//   timeout : this wait cycle is the last allowed one and MOC is still low
module sparc_mem_wait #(
  parameter int MOC_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic Clk,
  input  logic Clr,
  input  logic in_wait,
  input  logic moc,
  output logic timeout
);

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MOC_TIMEOUT);
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(MOC_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero outside the wait states, so every access starts from zero.
  // Counting saturates at the limit instead of wrapping.
  always_ff @(posedge Clk) begin
    if (Clr || !in_wait) begin
      cnt <= '0;
    end else if (!moc && cnt != LIMIT) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // MOC in the final cycle still completes the access.
  assign timeout = in_wait && !moc && (cnt == LAST);

endmodule

// File: rtl/sparc_control_unit.sv
// Hardwired microsequencer for a SPARC V8 subset (format-3 ALU, SETHI, Bicc,
// CALL, LD, ST). Fetch/decode/execute; drives every datapath strobe.
// Ports:
//   Clk : clock, rising edge
//   Clr : synchronous active-high reset; forces S_RESET, masks strobes/selects
//   bus : sparc_control_unit_if.master (IR, MOC, BCOND, TCOND in; strobes,
//         mux selects, OpXX, Err, Illegal, State out)
// Outputs are decoded from the current state and IR; IR_Ld and MDR_Ld in the
// read-wait states are additionally qualified by MOC in the same cycle.
module sparc_control_unit
  import sparc_control_unit_pkg::*;
#(
  parameter int MOC_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input  logic                     Clk,
  input  logic                     Clr,
  sparc_control_unit_if.master     bus
);

  state_t      state;
  state_t      dec_nxt;
  logic        in_wait;
  logic        timeout;
  logic [1:0]  mb_src;

  logic        ir_ld, mar_ld, mdr_ld, pc_ld, npc_ld, npc_clr;
  logic        rf_we, fr_ld, mov, rw, mm, msa, mop, illegal;
  logic [1:0]  mb, mnp, mp, msc;
  logic [5:0]  opxx;

  // TCOND is reserved, and these IR fields only matter to the datapath.
  logic unused_inputs;
  assign unused_inputs = ^{bus.TCOND, bus.IR[29:25], bus.IR[18:14], bus.IR[12:0]};

  assign in_wait = (state == S_F1) || (state == S_LDM) || (state == S_STM);
  assign dec_nxt = decode_target(bus.IR[31:30], bus.IR[24:19]);
  assign mb_src  = bus.IR[13] ? MB_IMM : MB_RF;

  sparc_mem_wait #(
    .MOC_TIMEOUT (MOC_TIMEOUT),
    .CNT_W       (CNT_W)
  ) u_wait (
    .Clk     (Clk),
    .Clr     (Clr),
    .in_wait (in_wait),
    .moc     (bus.MOC),
    .timeout (timeout)
  );

  always_ff @(posedge Clk) begin
    if (Clr) begin
      state <= S_RESET;
    end else begin
      case (state)
        S_RESET: state <= S_INIT;
        S_INIT:  state <= S_F0;
        S_F0:    state <= S_F1;
        S_F1: begin
          if (bus.MOC)     state <= S_DEC;
          else if (timeout) state <= S_ERROR;
        end
        S_DEC:   state <= dec_nxt;
        S_ALU, S_SETHI, S_LDW: state <= S_PCU;
        // op3[2] separates st (000100) from ld (000000).
        S_LDSTA: state <= bus.IR[21] ? S_STD : S_LDM;
        S_LDM: begin
          if (bus.MOC)     state <= S_LDW;
          else if (timeout) state <= S_ERROR;
        end
        S_STD:   state <= S_STM;
        S_STM: begin
          if (bus.MOC)     state <= S_PCU;
          else if (timeout) state <= S_ERROR;
        end
        S_BR:    state <= bus.BCOND ? S_F0 : S_PCU;
        S_CALL, S_PCU: state <= S_F0;
        S_ERROR: state <= S_ERROR;
        default: state <= S_RESET;
      endcase
    end
  end

  always_comb begin
    ir_ld   = 1'b0;  mar_ld = 1'b0;  mdr_ld = 1'b0;
    pc_ld   = 1'b0;  npc_ld = 1'b0;  npc_clr = 1'b0;
    rf_we   = 1'b0;  fr_ld  = 1'b0;  mov = 1'b0;  rw = 1'b0;
    mm      = 1'b0;  msa    = 1'b0;  mop = 1'b0;  illegal = 1'b0;
    mb      = MB_RF; mnp    = 2'b00; mp  = MP_ZERO; msc = MSC_RD;
    opxx    = OP_ADD;
    if (!Clr) begin
      case (state)
        S_RESET: begin
          pc_ld = 1'b1; mp = MP_ZERO; npc_clr = 1'b1;
        end
        S_INIT: begin
          npc_ld = 1'b1; mnp = MNP_NPC4;
        end
        S_F0: begin
          mb = MB_MUXC; mop = 1'b1; opxx = OP_PASS_B; mar_ld = 1'b1;
        end
        S_F1: begin
          mov = 1'b1; rw = 1'b1; ir_ld = bus.MOC;
        end
        S_DEC: begin
          illegal = (dec_nxt == S_PCU);
        end
        S_ALU: begin
          rf_we = 1'b1; mb = mb_src; fr_ld = bus.IR[23];
        end
        S_SETHI: begin
          mb = MB_IMM; mop = 1'b1; opxx = OP_PASS_B; rf_we = 1'b1;
        end
        S_LDSTA: begin
          mb = mb_src; mop = 1'b1; opxx = OP_ADD; mar_ld = 1'b1;
        end
        S_LDM: begin
          mov = 1'b1; rw = 1'b1; mdr_ld = bus.MOC;
        end
        S_LDW: begin
          mb = MB_MDR; mop = 1'b1; opxx = OP_PASS_B; rf_we = 1'b1;
        end
        S_STD: begin
          msa = 1'b1; mop = 1'b1; opxx = OP_PASS_A; mm = 1'b1; mdr_ld = 1'b1;
        end
        S_STM: begin
          mov = 1'b1;
        end
        S_BR: begin
          if (bus.BCOND) begin
            pc_ld = 1'b1; mp = MP_NPC; npc_ld = 1'b1; mnp = MNP_DISP;
          end
        end
        S_CALL: begin
          // r15 <- PC alongside the taken-branch PC/NPC update.
          msc = MSC_R15; mb = MB_MUXC; mop = 1'b1; opxx = OP_PASS_B;
          rf_we = 1'b1;
          pc_ld = 1'b1; mp = MP_NPC; npc_ld = 1'b1; mnp = MNP_DISP;
        end
        S_PCU: begin
          pc_ld = 1'b1; mp = MP_NPC; npc_ld = 1'b1; mnp = MNP_NPC4;
        end
        default: ;
      endcase
    end
  end

  assign bus.IR_Ld          = ir_ld;
  assign bus.MAR_Ld         = mar_ld;
  assign bus.MDR_Ld         = mdr_ld;
  assign bus.PC_Ld          = pc_ld;
  assign bus.NPC_Ld         = npc_ld;
  assign bus.nPC_Clr        = npc_clr;
  assign bus.RF_Load_Enable = rf_we;
  assign bus.FR_Ld          = fr_ld;
  assign bus.MOV            = mov;
  assign bus.RW             = rw;
  assign bus.Type           = TYPE_WORD;
  // MA and MC never leave their first input in this instruction subset.
  assign bus.MA             = 2'b00;
  assign bus.MC             = 1'b0;
  assign bus.MB             = mb;
  assign bus.MNP            = mnp;
  assign bus.MP             = mp;
  assign bus.MSc            = msc;
  assign bus.MM             = mm;
  assign bus.MSa            = msa;
  assign bus.MOP            = mop;
  assign bus.OpXX           = opxx;
  // Err follows the sticky trap state; Clr clears it at the edge.
  assign bus.Err            = (state == S_ERROR);
  assign bus.Illegal        = illegal;
  assign bus.State          = state;

endmodule

// File: tb/tb_sparc_control_unit.sv
module tb_sparc_control_unit;

  localparam logic [3:0] ST_RESET = 4'd0,  ST_INIT = 4'd1,  ST_F0 = 4'd2,
                         ST_F1 = 4'd3,     ST_DEC = 4'd4,   ST_ALU = 4'd5,
                         ST_SETHI = 4'd6,  ST_LDSTA = 4'd7, ST_LDM = 4'd8,
                         ST_LDW = 4'd9,    ST_STD = 4'd10,  ST_STM = 4'd11,
                         ST_BR = 4'd12,    ST_CALL = 4'd13, ST_PCU = 4'd14,
                         ST_ERROR = 4'd15;

  localparam int C_ALU = 0, C_SETHI = 1, C_LD = 2, C_ST = 3, C_BR = 4,
                 C_CALL = 5, C_ILL = 6;

  typedef struct packed {
    logic [3:0] st;
    logic ir_ld, mar_ld, mdr_ld, pc_ld, npc_ld, npc_clr;
    logic rf, fr, mov, rw, err, ill;
    logic [1:0] ty, ma, mb, mnp, mp, msc;
    logic mc, mm, msa, mop;
    logic [5:0] opxx;
  } obs_t;

  typedef struct packed {
    logic clr, moc, bcond;
    logic [31:0] ir;
  } drv_t;

  logic Clk;
  logic Clr;
  sparc_control_unit_if cu_if();

  sparc_control_unit #(.MOC_TIMEOUT(16), .CNT_W(5)) dut (
    .Clk (Clk),
    .Clr (Clr),
    .bus (cu_if)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  drv_t drv_q[$];
  obs_t exp_q[$];
  int   tag_q[$];
  logic [31:0] cur_ir;
  int   step;
  int   n_checks;
  int   n_pass;

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  function automatic obs_t blank(input logic [3:0] st);
    obs_t o;
    o = '0;
    o.st = st;
    o.ty = 2'b10;
    return o;
  endfunction

  function automatic obs_t sample();
    obs_t o;
    o.st = cu_if.State;       o.ir_ld = cu_if.IR_Ld;   o.mar_ld = cu_if.MAR_Ld;
    o.mdr_ld = cu_if.MDR_Ld;  o.pc_ld = cu_if.PC_Ld;   o.npc_ld = cu_if.NPC_Ld;
    o.npc_clr = cu_if.nPC_Clr; o.rf = cu_if.RF_Load_Enable; o.fr = cu_if.FR_Ld;
    o.mov = cu_if.MOV;        o.rw = cu_if.RW;         o.err = cu_if.Err;
    o.ill = cu_if.Illegal;    o.ty = cu_if.Type;       o.ma = cu_if.MA;
    o.mb = cu_if.MB;          o.mnp = cu_if.MNP;       o.mp = cu_if.MP;
    o.msc = cu_if.MSc;        o.mc = cu_if.MC;         o.mm = cu_if.MM;
    o.msa = cu_if.MSa;        o.mop = cu_if.MOP;       o.opxx = cu_if.OpXX;
    return o;
  endfunction

  // One cycle of stimulus plus the response the reference expects for it.
  task automatic put(input logic clr, input logic moc, input logic bc, input obs_t e);
    drv_t d;
    d.clr = clr; d.moc = moc; d.bcond = bc; d.ir = cur_ir;
    drv_q.push_back(d);
    exp_q.push_back(e);
    tag_q.push_back(step);
  endtask

  // n cycles with Clr high, then the two bring-up cycles.
  task automatic clr_cycles(input int n, input logic [3:0] st0);
    obs_t e;
    for (int k = 0; k < n; k++) begin
      e = blank((k == 0) ? st0 : ST_RESET);
      e.err = (e.st == ST_ERROR);
      put(1'b1, rnd(), rnd(), e);
    end
    e = blank(ST_RESET); e.pc_ld = 1; e.mp = 2'b00; e.npc_clr = 1;
    put(1'b0, rnd(), rnd(), e);
    e = blank(ST_INIT); e.npc_ld = 1; e.mnp = 2'b11;
    put(1'b0, rnd(), rnd(), e);
  endtask

  task automatic f0_cycle();
    obs_t e;
    e = blank(ST_F0); e.mb = 2'b10; e.mop = 1; e.opxx = 6'h3F; e.mar_ld = 1;
    put(1'b0, rnd(), rnd(), e);
  endtask

  // Fetch whose memory answers on the w-th wait cycle; IR shows the word then.
  task automatic fetch(input logic [31:0] ir, input int w);
    obs_t e;
    f0_cycle();
    for (int k = 1; k <= w; k++) begin
      e = blank(ST_F1); e.mov = 1; e.rw = 1;
      if (k == w) begin
        cur_ir = ir;
        e.ir_ld = 1;
        put(1'b0, 1'b1, rnd(), e);
      end else begin
        put(1'b0, 1'b0, rnd(), e);
      end
    end
  endtask

  task automatic pcu();
    obs_t e;
    e = blank(ST_PCU); e.pc_ld = 1; e.mp = 2'b11; e.npc_ld = 1; e.mnp = 2'b11;
    put(1'b0, rnd(), rnd(), e);
  endtask

  task automatic run_instr(input int cls, input logic [31:0] ir, input int fw,
                           input int mw, input logic bc);
    obs_t e;
    fetch(ir, fw);
    e = blank(ST_DEC); e.ill = (cls == C_ILL);
    put(1'b0, rnd(), rnd(), e);
    case (cls)
      C_ALU: begin
        e = blank(ST_ALU); e.rf = 1; e.mb = ir[13] ? 2'b01 : 2'b00; e.fr = ir[23];
        put(1'b0, rnd(), rnd(), e);
        pcu();
      end
      C_SETHI: begin
        e = blank(ST_SETHI); e.mb = 2'b01; e.mop = 1; e.opxx = 6'h3F; e.rf = 1;
        put(1'b0, rnd(), rnd(), e);
        pcu();
      end
      C_LD, C_ST: begin
        e = blank(ST_LDSTA); e.mb = ir[13] ? 2'b01 : 2'b00; e.mop = 1;
        e.opxx = 6'h00; e.mar_ld = 1;
        put(1'b0, rnd(), rnd(), e);
        if (cls == C_LD) begin
          for (int k = 1; k <= mw; k++) begin
            e = blank(ST_LDM); e.mov = 1; e.rw = 1; e.mdr_ld = (k == mw);
            put(1'b0, (k == mw), rnd(), e);
          end
          e = blank(ST_LDW); e.mb = 2'b11; e.mop = 1; e.opxx = 6'h3F; e.rf = 1;
          put(1'b0, rnd(), rnd(), e);
        end else begin
          e = blank(ST_STD); e.msa = 1; e.mop = 1; e.opxx = 6'h3E; e.mm = 1;
          e.mdr_ld = 1;
          put(1'b0, rnd(), rnd(), e);
          for (int k = 1; k <= mw; k++) begin
            e = blank(ST_STM); e.mov = 1;
            put(1'b0, (k == mw), rnd(), e);
          end
        end
        pcu();
      end
      C_BR: begin
        e = blank(ST_BR);
        if (bc) begin
          e.pc_ld = 1; e.mp = 2'b11; e.npc_ld = 1; e.mnp = 2'b10;
        end
        put(1'b0, rnd(), bc, e);
        if (!bc) pcu();
      end
      C_CALL: begin
        e = blank(ST_CALL); e.msc = 2'b01; e.mb = 2'b10; e.mop = 1;
        e.opxx = 6'h3F; e.rf = 1;
        e.pc_ld = 1; e.mp = 2'b11; e.npc_ld = 1; e.mnp = 2'b10;
        put(1'b0, rnd(), rnd(), e);
      end
      default: pcu();
    endcase
  endtask

  function automatic logic [31:0] make_ir(input int cls);
    logic [31:0] r;
    logic [2:0]  bad_op2 [6];
    bad_op2 = '{3'b000, 3'b001, 3'b011, 3'b101, 3'b110, 3'b111};
    r = $urandom;
    case (cls)
      C_ALU:   begin r[31:30] = 2'b10; r[24:23] = 2'b00; end
      C_SETHI: begin r[31:30] = 2'b00; r[24:22] = 3'b100; end
      C_LD:    begin r[31:30] = 2'b11; r[24:19] = 6'b000000; end
      C_ST:    begin r[31:30] = 2'b11; r[24:19] = 6'b000100; end
      C_BR:    begin r[31:30] = 2'b00; r[24:22] = 3'b010; end
      C_CALL:  r[31:30] = 2'b01;
      default: begin
        case ($urandom_range(0, 3))
          0: begin r[31:30] = 2'b11; r[24:19] = 6'b111111; end
          1: begin r[31:30] = 2'b10; r[24:23] = 2'($urandom_range(1, 3)); end
          2: begin r[31:30] = 2'b00; r[24:22] = bad_op2[$urandom_range(0, 5)]; end
          default: begin
            r[31:30] = 2'b11;
            while (r[24:19] == 6'b000000 || r[24:19] == 6'b000100) r[24:19] = 6'($urandom);
          end
        endcase
      end
    endcase
    return r;
  endfunction

  task automatic driver();
    drv_t d;
    while (drv_q.size() != 0) begin
      @(negedge Clk);
      d = drv_q.pop_front();
      Clr         = d.clr;
      cu_if.MOC   = d.moc;
      cu_if.BCOND = d.bcond;
      cu_if.IR    = d.ir;
      cu_if.TCOND = rnd();
    end
  endtask

  task automatic monitor();
    obs_t got;
    obs_t want;
    int   tag;
    int   cyc;
    cyc = 0;
    while (exp_q.size() != 0) begin
      @(negedge Clk);
      #1;
      want = exp_q.pop_front();
      tag  = tag_q.pop_front();
      got  = sample();
      n_checks++;
      if (got !== want)
        $display("FAIL cyc%0d step%0d state%0d: got %h required %h",
                 cyc, tag, want.st, got, want);
      else
        n_pass++;
      cyc++;
    end
  endtask

  initial begin
    obs_t e;
    int   cls;
    Clr = 1'b1;
    cu_if.IR = '0; cu_if.MOC = 1'b0; cu_if.BCOND = 1'b0; cu_if.TCOND = 1'b0;
    cur_ir = '0; step = 0; n_checks = 0; n_pass = 0;

    // Directed scenarios
    clr_cycles(3, ST_RESET);
    step = 1;  run_instr(C_ALU,  32'h82006005, 2, 1, 1'b0);
    step = 2;  run_instr(C_LD,   32'hC2006008, 1, 3, 1'b0);
    step = 3;  run_instr(C_BR,   32'h10800004, 1, 1, 1'b1);
    step = 4;  run_instr(C_BR,   32'h10800004, 3, 1, 1'b0);
    step = 5;  run_instr(C_ST,   make_ir(C_ST), 1, 2, 1'b0);
    step = 6;  run_instr(C_CALL, 32'h40000010, 1, 1, 1'b0);
    step = 7;  run_instr(C_ILL,  32'hC1F80000, 16, 1, 1'b0);
    step = 8;  run_instr(C_SETHI, make_ir(C_SETHI), 1, 1, 1'b0);

    // Randomized program
    for (int i = 0; i < 50; i++) begin
      step = 100 + i;
      cls = $urandom_range(0, 6);
      run_instr(cls, make_ir(cls), $urandom_range(1, 6), $urandom_range(1, 6), rnd());
    end

    // Fetch that never completes: 16 wait cycles, then sticky error
    step = 200;
    f0_cycle();
    for (int k = 0; k < 16; k++) begin
      e = blank(ST_F1); e.mov = 1; e.rw = 1;
      put(1'b0, 1'b0, rnd(), e);
    end
    for (int k = 0; k < 5; k++) begin
      e = blank(ST_ERROR); e.err = 1;
      put(1'b0, rnd(), rnd(), e);
    end
    step = 201; clr_cycles(1, ST_ERROR);

    // Clr in the middle of a fetch wait
    step = 202;
    f0_cycle();
    for (int k = 0; k < 2; k++) begin
      e = blank(ST_F1); e.mov = 1; e.rw = 1;
      put(1'b0, 1'b0, rnd(), e);
    end
    clr_cycles(1, ST_F1);
    step = 203; run_instr(C_ALU, make_ir(C_ALU), 2, 1, 1'b0);

    fork
      driver();
      monitor();
    join

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
